// File: rtl/poly_stream_addr_seq_pkg.sv
// rtl/poly_stream_addr_seq_pkg.sv - shared constants for the poly-stream address sequencer
//
// Purpose: memory geometry defaults, FSM state encodings, credit counter width
//          and a width helper shared by the sequencer top and its walker.
// Ports:   none (package).

package poly_stream_addr_seq_pkg;

   // ABR memory geometry defaults
   localparam int ABR_MEM_ADDR_WIDTH = 15;
   localparam int MLKEM_N            = 256;

   // Wide enough for up to 7 outstanding reads
   localparam int PSS_CREDIT_W = 3;

   // Sequencer FSM encodings
   localparam logic [0:0] PSS_IDLE = 1'b0;
   localparam logic [0:0] PSS_RUN  = 1'b1;

   // Index width that stays legal when only one poly is allowed
   function automatic int pss_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/poly_stream_addr_seq_walker.sv
// rtl/poly_stream_addr_seq_walker.sv - word/poly counter with base+stride accumulator
//
// Purpose: walks base + p*stride + w for w in 0..WORDS_POLY-1 and p in 0..last,
//          building the poly base by repeated stride addition (no multiplier).
// Ports:
//   clk_i        clock
//   clr_i        synchronous clear of all state
//   restart_i    load base/stride, zero counters (wins over advance_i)
//   base_i       first poly base address
//   stride_i     address delta between consecutive poly bases
//   last_poly_i  index of the final poly of the command
//   advance_i    step to the next word
//   addr_o       current address
//   idx_o        current poly index
//   last_o       current word is the final word of the final poly

module poly_stream_addr_seq_walker #(
   parameter int AW         = 15,
   parameter int WORDS_POLY = 64,
   parameter int NPW        = 3,
   parameter int PIW        = 2
) (
   input  logic           clk_i,
   input  logic           clr_i,
   input  logic           restart_i,
   input  logic [AW-1:0]  base_i,
   input  logic [AW-1:0]  stride_i,
   input  logic [NPW-1:0] last_poly_i,
   input  logic           advance_i,
   output logic [AW-1:0]  addr_o,
   output logic [PIW-1:0] idx_o,
   output logic           last_o
);

   localparam int WW = $clog2(WORDS_POLY);

   logic [WW-1:0]  word_q, word_d;
   logic [PIW-1:0] poly_q, poly_d;
   logic [AW-1:0]  base_q, base_d;
   logic [AW-1:0]  stride_q, stride_d;
   logic           word_end;

   assign word_end = (word_q == WW'(WORDS_POLY - 1));

   always_comb begin
      word_d   = word_q;
      poly_d   = poly_q;
      base_d   = base_q;
      stride_d = stride_q;
      if (restart_i) begin
         word_d   = '0;
         poly_d   = '0;
         base_d   = base_i;
         stride_d = stride_i;
      end else if (advance_i) begin
         if (word_end) begin
            word_d = '0;
            poly_d = poly_q + PIW'(1);
            // Address arithmetic wraps modulo 2^AW by width
            base_d = base_q + stride_q;
         end else begin
            word_d = word_q + WW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         word_q   <= '0;
         poly_q   <= '0;
         base_q   <= '0;
         stride_q <= '0;
      end else begin
         word_q   <= word_d;
         poly_q   <= poly_d;
         base_q   <= base_d;
         stride_q <= stride_d;
      end
   end

   assign addr_o = base_q + AW'(word_q);
   assign idx_o  = poly_q;
   assign last_o = word_end && (NPW'(poly_q) == last_poly_i);

endmodule

// File: rtl/poly_stream_addr_seq.sv
// rtl/poly_stream_addr_seq.sv - source-read / destination-write address sequencer for poly streams
//
// Purpose: on a legal command, issues source reads up to RD_CREDITS ahead of the
//          datapath and steers destination writes for 1..MAX_POLY polys placed at a
//          programmable stride; pulses done after the final write.
// Ports:
//   clk_i, reset_i, zeroize_i     clock, sync active-high reset, sync clear
//   start_i, num_poly_i           command strobe and poly count (sampled at start)
//   src_base_addr_i               read base (sampled at start)
//   dest_base_addr_i              write base (sampled at start)
//   poly_stride_i                 poly base delta, 0 selects WORDS_POLY (sampled at start)
//   mem_rd_en_o, mem_rd_addr_o    read request and address
//   wr_valid_i                    datapath write word available
//   mem_wr_en_o, mem_wr_addr_o    write strobe and address
//   poly_idx_o                    index of the poly being written
//   busy_o, done_o, err_cmd_o     running, completion pulse, illegal command/protocol pulse

module poly_stream_addr_seq
   import poly_stream_addr_seq_pkg::*;
#(
   parameter int AW         = ABR_MEM_ADDR_WIDTH,
   parameter int WORDS_POLY = MLKEM_N / 4,
   parameter int MAX_POLY   = 4,
   parameter int RD_CREDITS = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              zeroize_i,
   input  logic                              start_i,
   input  logic [$clog2(MAX_POLY+1)-1:0]     num_poly_i,
   input  logic [AW-1:0]                     src_base_addr_i,
   input  logic [AW-1:0]                     dest_base_addr_i,
   input  logic [AW-1:0]                     poly_stride_i,
   output logic                              mem_rd_en_o,
   output logic [AW-1:0]                     mem_rd_addr_o,
   input  logic                              wr_valid_i,
   output logic                              mem_wr_en_o,
   output logic [AW-1:0]                     mem_wr_addr_o,
   output logic [pss_idx_w(MAX_POLY)-1:0]    poly_idx_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              err_cmd_o
);

   localparam int NPW = $clog2(MAX_POLY + 1);
   localparam int PIW = pss_idx_w(MAX_POLY);

   logic [0:0]              state_q, state_d;
   logic [NPW-1:0]          num_poly_q, num_poly_d;
   logic [PSS_CREDIT_W-1:0] credit_q, credit_d;
   logic                    rd_all_q, rd_all_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic           clr, run, cmd_ok, start_acc, rd_fire, wr_acc, wr_fin;
   logic [AW-1:0]  stride_eff, rd_addr, wr_addr;
   logic [NPW-1:0] last_poly;
   logic           rd_last, wr_last;
   logic [PIW-1:0] rd_idx_unused, wr_idx;

   assign clr        = reset_i | zeroize_i;
   assign run        = (state_q == PSS_RUN);
   assign cmd_ok     = (num_poly_i != '0) && (num_poly_i <= NPW'(MAX_POLY));
   assign start_acc  = start_i && !run && cmd_ok;
   assign stride_eff = (poly_stride_i == '0) ? AW'(WORDS_POLY) : poly_stride_i;
   assign last_poly  = num_poly_q - NPW'(1);

   // Reads run ahead of the datapath only while credits remain
   assign rd_fire = run && !rd_all_q && (credit_q < PSS_CREDIT_W'(RD_CREDITS));
   // A write with no read outstanding has no data behind it: drop it
   assign wr_acc  = run && wr_valid_i && (credit_q != '0);
   assign wr_fin  = wr_acc && wr_last;

   always_comb begin
      state_d    = state_q;
      num_poly_d = num_poly_q;
      rd_all_d   = rd_all_q;
      credit_d   = credit_q + PSS_CREDIT_W'(rd_fire) - PSS_CREDIT_W'(wr_acc);
      done_d     = wr_fin;
      err_d      = (start_i && (run || !cmd_ok)) || (run && wr_valid_i && (credit_q == '0));
      if (start_acc) begin
         state_d    = PSS_RUN;
         num_poly_d = num_poly_i;
         rd_all_d   = 1'b0;
      end else if (wr_fin) begin
         state_d = PSS_IDLE;
      end
      if (rd_fire && rd_last) begin
         rd_all_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q    <= PSS_IDLE;
         num_poly_q <= '0;
         credit_q   <= '0;
         rd_all_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_poly_q <= num_poly_d;
         credit_q   <= credit_d;
         rd_all_q   <= rd_all_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   poly_stream_addr_seq_walker #(
      .AW(AW), .WORDS_POLY(WORDS_POLY), .NPW(NPW), .PIW(PIW)
   ) u_rd_walker (
      .clk_i       (clk_i),
      .clr_i       (clr),
      .restart_i   (start_acc),
      .base_i      (src_base_addr_i),
      .stride_i    (stride_eff),
      .last_poly_i (last_poly),
      .advance_i   (rd_fire),
      .addr_o      (rd_addr),
      .idx_o       (rd_idx_unused),
      .last_o      (rd_last)
   );

   poly_stream_addr_seq_walker #(
      .AW(AW), .WORDS_POLY(WORDS_POLY), .NPW(NPW), .PIW(PIW)
   ) u_wr_walker (
      .clk_i       (clk_i),
      .clr_i       (clr),
      .restart_i   (start_acc),
      .base_i      (dest_base_addr_i),
      .stride_i    (stride_eff),
      .last_poly_i (last_poly),
      .advance_i   (wr_acc),
      .addr_o      (wr_addr),
      .idx_o       (wr_idx),
      .last_o      (wr_last)
   );

   // Address/index outputs read as zero outside RUN
   assign mem_rd_en_o   = rd_fire;
   assign mem_rd_addr_o = rd_fire ? rd_addr : '0;
   assign mem_wr_en_o   = wr_acc;
   assign mem_wr_addr_o = run ? wr_addr : '0;
   assign poly_idx_o    = run ? wr_idx : '0;
   assign busy_o        = run;
   assign done_o        = done_q;
   assign err_cmd_o     = err_q;

endmodule
